// File: rtl/wave_dds_gen_pkg.sv
// Shared definitions for the DDS waveform generator: mode encodings, unity gain,
// pipeline depth and the sine table generator used to fill the waveform ROM.
package wave_dds_gen_pkg;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_SAW    = 2'd3
  } wave_sel_t;

  localparam int AMP_UNITY    = 256;
  localparam int PIPE_LATENCY = 3;

  // One full sine period in offset binary, using Bhaskara's rational approximation
  // so the table is exact integer arithmetic and identical in every tool.
  function automatic longint sine_sample(longint idx, longint addr_w, longint data_w);
    longint half, mid, p, q, num, den, mag;
    half = 64'sd1 <<< (addr_w - 64'sd1);
    mid  = 64'sd1 <<< (data_w - 64'sd1);
    p    = idx % half;
    q    = p * (half - p);
    num  = 64'sd16 * q * (mid - 64'sd1);
    den  = 64'sd5 * half * half - 64'sd4 * q;
    mag  = (num + den / 64'sd2) / den;
    return (idx < half) ? mid + mag : mid - mag;
  endfunction

endpackage

// File: rtl/wave_dds_gen_if.sv
// Control, configuration and sample-output bundle of the DDS waveform generator.
interface wave_dds_gen_if #(
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
);
  logic              en;
  logic              phase_clr;
  logic              cfg_load;
  logic [ACC_W-1:0]  freq_word;
  logic [ADDR_W-1:0] phase_ofs;
  logic [1:0]        wave_sel;
  logic [8:0]        amp;
  logic [DATA_W-1:0] wave_out;
  logic              wave_valid;
  logic              sync;

  modport master (
    output en, phase_clr, cfg_load, freq_word, phase_ofs, wave_sel, amp,
    input  wave_out, wave_valid, sync
  );

  modport slave (
    input  en, phase_clr, cfg_load, freq_word, phase_ofs, wave_sel, amp,
    output wave_out, wave_valid, sync
  );
endinterface

// File: rtl/wave_dds_gen_rom.sv
// Full-period sine ROM with registered, read-enabled output.
module wave_rom
  import wave_dds_gen_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] data_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2**ADDR_W; gi++) begin : g_init
      assign mem[gi] = DATA_W'(sine_sample(longint'(gi), longint'(ADDR_W), longint'(DATA_W)));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg <= '0;
    end else if (rd_en) begin
      data_reg <= mem[addr];
    end
  end

  assign data = data_reg;

endmodule

// File: rtl/wave_dds_gen.sv
// Phase-accumulator DDS: accumulator -> address (stage 1) -> raw sample (stage 2)
// -> amplitude-scaled output (stage 3), with a wrap tag riding along as sync.
module wave_dds_gen
  import wave_dds_gen_pkg::*;
#(
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
) (
  input logic               clk,
  input logic               rst,
  wave_dds_gen_if.slave     bus
);

  logic [ACC_W-1:0]  freq_reg;
  logic [ADDR_W-1:0] ofs_reg;
  wave_sel_t         sel_reg;
  logic [8:0]        amp_reg;

  logic [ACC_W-1:0]  acc_reg;
  logic              acc_wrap_reg;
  logic [ACC_W:0]    acc_sum;

  logic [ADDR_W-1:0] addr1_reg;
  wave_sel_t         sel1_reg;
  logic              v1_reg, sync1_reg;

  logic [DATA_W-1:0] alt2_reg, alt_next;
  wave_sel_t         sel2_reg;
  logic              v2_reg, sync2_reg;
  logic [DATA_W-1:0] rom_data;

  logic [DATA_W-1:0] wave_out_reg;
  logic              valid_reg, sync_reg;

  logic [DATA_W-1:0] raw;
  logic [8:0]        amp_eff;
  logic [DATA_W+8:0] prod;

  assign acc_sum = {1'b0, acc_reg} + {1'b0, freq_reg};

  // Non-sine shapes are pure functions of the address, registered so they line up with the ROM.
  always_comb begin
    alt_next = addr1_reg[ADDR_W-1 -: DATA_W];
    case (sel1_reg)
      WAVE_SQUARE: alt_next = addr1_reg[ADDR_W-1] ? {DATA_W{1'b0}} : {DATA_W{1'b1}};
      WAVE_TRI:    alt_next = addr1_reg[ADDR_W-2 -: DATA_W] ^ {DATA_W{addr1_reg[ADDR_W-1]}};
      default:     alt_next = addr1_reg[ADDR_W-1 -: DATA_W];
    endcase
  end

  wave_rom #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rom (
    .clk   (clk),
    .rst   (rst),
    .rd_en (v1_reg),
    .addr  (addr1_reg),
    .data  (rom_data)
  );

  assign raw     = (sel2_reg == WAVE_SINE) ? rom_data : alt2_reg;
  assign amp_eff = (amp_reg > 9'(AMP_UNITY)) ? 9'(AMP_UNITY) : amp_reg;
  assign prod    = {9'd0, raw} * {{DATA_W{1'b0}}, amp_eff};

  always_ff @(posedge clk) begin
    if (rst) begin
      freq_reg     <= '0;
      ofs_reg      <= '0;
      sel_reg      <= WAVE_SINE;
      amp_reg      <= 9'(AMP_UNITY);
      acc_reg      <= '0;
      acc_wrap_reg <= 1'b0;
      addr1_reg    <= '0;
      sel1_reg     <= WAVE_SINE;
      v1_reg       <= 1'b0;
      sync1_reg    <= 1'b0;
      alt2_reg     <= '0;
      sel2_reg     <= WAVE_SINE;
      v2_reg       <= 1'b0;
      sync2_reg    <= 1'b0;
      wave_out_reg <= '0;
      valid_reg    <= 1'b0;
      sync_reg     <= 1'b0;
    end else begin
      if (bus.cfg_load) begin
        freq_reg <= bus.freq_word;
        ofs_reg  <= bus.phase_ofs;
        sel_reg  <= wave_sel_t'(bus.wave_sel);
        amp_reg  <= bus.amp;
      end

      // The wrap flag belongs to the accumulator value it produced, so a clear drops it.
      if (bus.phase_clr) begin
        acc_reg      <= '0;
        acc_wrap_reg <= 1'b0;
      end else if (bus.en) begin
        acc_reg      <= acc_sum[ACC_W-1:0];
        acc_wrap_reg <= acc_sum[ACC_W];
      end

      v1_reg <= bus.en;
      if (bus.en) begin
        addr1_reg <= acc_reg[ACC_W-1 -: ADDR_W] + ofs_reg;
        sel1_reg  <= sel_reg;
        sync1_reg <= acc_wrap_reg;
      end

      v2_reg <= v1_reg;
      if (v1_reg) begin
        alt2_reg  <= alt_next;
        sel2_reg  <= sel1_reg;
        sync2_reg <= sync1_reg;
      end

      valid_reg <= v2_reg;
      sync_reg  <= v2_reg & sync2_reg;
      if (v2_reg) begin
        wave_out_reg <= prod[DATA_W+7:8];
      end
    end
  end

  assign bus.wave_out   = wave_out_reg;
  assign bus.wave_valid = valid_reg;
  assign bus.sync       = sync_reg;

endmodule

// File: tb/tb_wave_dds_gen.sv
// Directed bench for wave_dds_gen: arithmetic phase/sample model checked every cycle,
// plus literal expectations on captured sample sequences.
module tb_wave_dds_gen;
  import wave_dds_gen_pkg::*;

  localparam longint TWO32 = 64'sd4294967296;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wave_dds_gen_if #(.ACC_W(32), .ADDR_W(14), .DATA_W(8)) bus ();

  wave_dds_gen #(.ACC_W(32), .ADDR_W(14), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;
  bit cap_on = 1'b0;
  logic [7:0] cap_q[$];
  bit         cap_s[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Sample value for a given phase straight from the waveform definitions.
  function automatic logic [7:0] model_sample(longint acc, int ofs, int sel, int amp);
    int a, raw, g;
    a = int'(((acc >>> 18) + longint'(ofs)) % 64'sd16384);
    case (sel)
      0:       raw = int'(sine_sample(longint'(a), 64'sd14, 64'sd8));
      1:       raw = (a < 8192) ? 255 : 0;
      2:       raw = (a < 8192) ? ((a >> 5) & 255) : 255 - ((a >> 5) & 255);
      default: raw = a >> 6;
    endcase
    g = (amp > AMP_UNITY) ? AMP_UNITY : amp;
    return 8'((raw * g) / 256);
  endfunction

  longint     m_acc, m_fw, m_sum;
  bit         m_wrap;
  int         m_ofs, m_sel, m_amp;
  bit         d_v[2];
  bit         d_s[2];
  logic [7:0] d_y[2];
  logic [7:0] e_out;
  bit         e_valid, e_sync;

  task automatic model_reset();
    m_acc = 0; m_fw = 0; m_wrap = 1'b0;
    m_ofs = 0; m_sel = 0; m_amp = AMP_UNITY;
    for (int i = 0; i < 2; i++) begin
      d_v[i] = 1'b0; d_s[i] = 1'b0; d_y[i] = 8'd0;
    end
    e_out = 8'd0; e_valid = 1'b0; e_sync = 1'b0;
  endtask

  // Model: a sample is computed when its phase is consumed and appears PIPE_LATENCY clocks later.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (rst === 1'b1) begin
        model_reset();
      end else begin
        e_valid = d_v[1];
        e_sync  = d_v[1] & d_s[1];
        if (d_v[1]) e_out = d_y[1];
        d_v[1] = d_v[0]; d_s[1] = d_s[0]; d_y[1] = d_y[0];
        d_v[0] = bus.en;
        if (bus.en) begin
          d_y[0] = model_sample(m_acc, m_ofs, m_sel, m_amp);
          d_s[0] = m_wrap;
        end
        if (bus.phase_clr) begin
          m_acc = 0; m_wrap = 1'b0;
        end else if (bus.en) begin
          m_sum  = m_acc + m_fw;
          m_wrap = (m_sum >= TWO32);
          m_acc  = m_sum % TWO32;
        end
        if (bus.cfg_load) begin
          m_fw  = longint'(bus.freq_word);
          m_ofs = int'(bus.phase_ofs);
          m_sel = int'(bus.wave_sel);
          m_amp = int'(bus.amp);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("valid", 32'(bus.wave_valid), 32'(e_valid));
      check("sync", 32'(bus.sync), 32'(e_sync));
      check("wave_out", 32'(bus.wave_out), 32'(e_out));
    end
    if (cap_on && bus.wave_valid === 1'b1) begin
      cap_q.push_back(bus.wave_out);
      cap_s.push_back(bus.sync);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg(input logic [31:0] fw, input logic [13:0] ofs, input logic [1:0] sel,
                     input logic [8:0] a);
    bus.freq_word = fw; bus.phase_ofs = ofs; bus.wave_sel = sel; bus.amp = a;
    bus.cfg_load = 1'b1;
    tick(1);
    bus.cfg_load = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic clear_cap();
    cap_q.delete();
    cap_s.delete();
  endtask

  task automatic stream(input int n);
    bus.en = 1'b1;
    tick(n);
    bus.en = 1'b0;
    tick(5);
  endtask

  task automatic expect_cap(input string name, input int idx, input int val);
    check(name, (idx < cap_q.size()) ? 32'(cap_q[idx]) : 32'hFFFF_FFFF, 32'(val));
  endtask

  task automatic report(input string name);
    $display("[%0t] %s: samples=%0d checks=%0d errors=%0d", $time, name, cap_q.size(), checks, errors);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.en = 1'b0; bus.phase_clr = 1'b0; bus.cfg_load = 1'b0;
    bus.freq_word = '0; bus.phase_ofs = '0; bus.wave_sel = '0; bus.amp = '0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    check("rst_wave_out", 32'(bus.wave_out), 32'd0);
    check("rst_valid", 32'(bus.wave_valid), 32'd0);
    check("rst_sync", 32'(bus.sync), 32'd0);

    // Pins on the reference model itself.
    check("pin_sine_0", 32'(sine_sample(64'sd0, 64'sd14, 64'sd8)), 32'd128);
    check("pin_sine_q1", 32'(sine_sample(64'sd4096, 64'sd14, 64'sd8)), 32'd255);
    check("pin_sine_half", 32'(sine_sample(64'sd8192, 64'sd14, 64'sd8)), 32'd128);
    check("pin_sine_q3", 32'(sine_sample(64'sd12288, 64'sd14, 64'sd8)), 32'd1);
    check("pin_saw_37", 32'(model_sample(64'sd37 * 64'sd16777216, 0, 3, 256)), 32'd37);
    check("pin_sq_amp300", 32'(model_sample(64'sd0, 0, 1, 300)), 32'd255);
    check("pin_sq_low", 32'(model_sample(64'sd2147483648, 0, 1, 128)), 32'd0);
    $display("latency=%0d model ready", PIPE_LATENCY);
    chk_on = 1'b1;
    cap_on = 1'b1;

    // Sine stepping one ROM address per sample.
    cfg(32'h0004_0000, 14'd0, WAVE_SINE, 9'd256);
    clear_cap();
    stream(20);
    check("sine_count", 32'(cap_q.size()), 32'd20);
    expect_cap("sine_first", 0, 128);
    for (int i = 0; i < 20; i++) expect_cap("sine_seq", i, int'(sine_sample(longint'(i), 64'sd14, 64'sd8)));
    report("sine");

    // Sawtooth ramp with one wrap.
    do_reset();
    cfg(32'h0100_0000, 14'd0, WAVE_SAW, 9'd256);
    clear_cap();
    stream(260);
    check("saw_count", 32'(cap_q.size()), 32'd260);
    for (int i = 0; i < 260; i++) begin
      expect_cap("saw_seq", i, i % 256);
      check("saw_sync", (i < cap_s.size()) ? 32'(cap_s[i]) : 32'd2, 32'(i == 256));
    end
    report("saw");

    // Square at half and saturated amplitude.
    do_reset();
    cfg(32'h8000_0000, 14'd0, WAVE_SQUARE, 9'd128);
    clear_cap();
    stream(6);
    for (int i = 0; i < 6; i++) expect_cap("sq_half", i, (i % 2 == 0) ? 127 : 0);
    cfg(32'h8000_0000, 14'd0, WAVE_SQUARE, 9'd300);
    clear_cap();
    stream(4);
    for (int i = 0; i < 4; i++) expect_cap("sq_sat", i, (i % 2 == 0) ? 255 : 0);
    report("square");

    // Mode switch mid-stream: load cycle still uses the old mode.
    do_reset();
    cfg(32'h0100_0000, 14'd0, WAVE_SAW, 9'd256);
    clear_cap();
    bus.en = 1'b1;
    tick(10);
    cfg(32'h0100_0000, 14'd0, WAVE_TRI, 9'd256);
    tick(10);
    bus.en = 1'b0;
    tick(5);
    check("sel_count", 32'(cap_q.size()), 32'd21);
    expect_cap("sel_saw9", 9, 9);
    expect_cap("sel_saw10", 10, 10);
    expect_cap("sel_tri11", 11, 22);
    expect_cap("sel_tri12", 12, 24);
    report("mode_switch");

    // Phase clear mid-stream with a phase offset.
    do_reset();
    cfg(32'h0100_0000, 14'd640, WAVE_SAW, 9'd256);
    clear_cap();
    bus.en = 1'b1;
    tick(7);
    bus.phase_clr = 1'b1;
    tick(1);
    bus.phase_clr = 1'b0;
    tick(5);
    bus.en = 1'b0;
    tick(5);
    check("clr_count", 32'(cap_q.size()), 32'd13);
    expect_cap("clr_before", 7, 17);
    expect_cap("clr_after", 8, 10);
    expect_cap("clr_last", 12, 14);
    for (int i = 0; i < 13; i++) check("clr_nosync", (i < cap_s.size()) ? 32'(cap_s[i]) : 32'd2, 32'd0);
    report("phase_clr");

    // Enable gap of five cycles.
    do_reset();
    cfg(32'h0100_0000, 14'd0, WAVE_SAW, 9'd256);
    clear_cap();
    bus.en = 1'b1;
    tick(8);
    bus.en = 1'b0;
    tick(4);
    check("gap_hold_out", 32'(bus.wave_out), 32'd7);
    check("gap_hold_valid", 32'(bus.wave_valid), 32'd0);
    tick(1);
    bus.en = 1'b1;
    tick(8);
    bus.en = 1'b0;
    tick(5);
    check("gap_count", 32'(cap_q.size()), 32'd16);
    for (int i = 0; i < 16; i++) expect_cap("gap_seq", i, i);
    report("en_gap");

    // Reset while streaming: defaults give a constant sine midpoint and no sync.
    do_reset();
    cfg(32'h0100_0000, 14'd0, WAVE_TRI, 9'd256);
    bus.en = 1'b1;
    tick(10);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rst2_wave_out", 32'(bus.wave_out), 32'd0);
    check("rst2_valid", 32'(bus.wave_valid), 32'd0);
    check("rst2_sync", 32'(bus.sync), 32'd0);
    clear_cap();
    tick(8);
    bus.en = 1'b0;
    tick(5);
    check("rst2_count", 32'(cap_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      expect_cap("rst2_const", i, 128);
      check("rst2_nosync", (i < cap_s.size()) ? 32'(cap_s[i]) : 32'd2, 32'd0);
    end
    report("reset_stream");

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wave_dds_gen.md
WAVE_DDS_GEN -- requirements
Module: wave_dds_gen

Interface
REQ-001 SHALL have parameters: ACC_W, default 32, phase accumulator width.
REQ-002 SHALL have parameters: ADDR_W, default 14, waveform ROM address width (2^ADDR_W samples per period).
REQ-003 SHALL have parameters: DATA_W, default 8, sample width (unsigned, offset binary).
REQ-004 SHALL have ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  advance phase and produce samples.
- phase_clr  in  1  force accumulator to 0.
- cfg_load  in  1  capture configuration inputs this cycle.
- freq_word  in  ACC_W  phase increment per sample.
- phase_ofs  in  ADDR_W  phase offset added to address.
- wave_sel  in  2  waveform mode: 0 sine, 1 square, 2 triangle, 3 sawtooth.
- amp  in  9  amplitude, 256 = unity.
- wave_out  out  DATA_W  scaled sample.
- wave_valid  out  1  wave_out holds a new sample.
- sync  out  1  sample is first after a phase wrap.

Function
REQ-005 SHALL latch freq_word, phase_ofs, wave_sel and amp into shadow registers on the cycle cfg_load=1; all datapath use SHALL read shadow registers only.
REQ-006 SHALL advance acc <= acc + freq_word_shadow (mod 2^ACC_W) on each cycle with en=1; acc SHALL hold when en=0.
REQ-007 phase_clr=1 SHALL set acc to 0 next cycle, overriding en; phase_clr and cfg_load together SHALL both take effect in that cycle.
REQ-008 A cycle where the acc addition carries out SHALL be tagged wrap; the tag SHALL travel with the sample and appear on sync.
REQ-009 Address SHALL be acc[ACC_W-1 -: ADDR_W] + phase_ofs_shadow, modulo 2^ADDR_W, registered (stage 1).
REQ-010 Stage 2 SHALL produce the raw sample:
- sine: ROM read, 1-cycle registered.
- square: addr MSB=0 -> all ones, else 0.
- sawtooth: addr[ADDR_W-1 -: DATA_W].
- triangle: addr[ADDR_W-2 -: DATA_W], bitwise-inverted when addr MSB=1.
All modes SHALL be aligned to the ROM latency.
REQ-011 Stage 3 SHALL output wave_out = (raw * min(amp,256)) >> 8, truncated to DATA_W; amp>256 SHALL saturate to unity.
REQ-012 Latency: an acc value formed at cycle n SHALL appear on wave_out at cycle n+3; wave_valid SHALL be en delayed by 3 cycles.
REQ-013 wave_sel change via cfg_load SHALL affect the first sample whose stage 1 follows the load, with no mixed-mode sample.
REQ-014 wave_out SHALL hold its last value while wave_valid=0.
REQ-015 freq_word=0 with en=1 SHALL yield a constant valid sample stream and never assert sync.

Reset
REQ-016 rst=1 SHALL clear acc, all pipeline registers, and shadow registers (freq 0, ofs 0, sine, amp 256).
REQ-017 Reset values SHALL be: wave_out=0, wave_valid=0, sync=0; in-flight samples SHALL be discarded.
REQ-018 rst SHALL override en, phase_clr and cfg_load.

Structure
REQ-019 Shared package SHALL hold wave_sel encodings (WAVE_SINE, WAVE_SQUARE, WAVE_TRI, WAVE_SAW), AMP_UNITY=256 and pipeline latency constant 3.
REQ-020 Sine storage SHALL be one sub-module wave_rom (ADDR_W x DATA_W, registered output, read-enable), initialised from a full-period sine file.

Verification
REQ-021 Reset, cfg freq_word=2^18, sine, en=1 -> first valid at cycle 3 after en; addr steps 1 per sample, wave_out matches ROM[0,1,2...].
REQ-022 Sawtooth, freq_word=2^24, amp=256 -> wave_out = 0,1,...,255 then 0; sync=1 on the sample at address 0 after the wrap, period 256 samples.
REQ-023 Square, amp=128, freq_word=2^31 -> wave_out alternates 127,0; amp=300 -> 255,0 (saturated).
REQ-024 Mid-stream phase_clr with en=1 -> 3 cycles later wave_out equals sample at phase_ofs_shadow; no sync asserted for the clear.
REQ-025 en low for 5 cycles mid-stream -> wave_valid low 5 cycles (delayed 3), wave_out held; the resumed sequence continues without phase gap.
REQ-026 rst asserted for 1 cycle during streaming -> next cycle outputs 0/0/0, shadow defaults restored, no stale sample emitted afterwards.
